// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control-sequence emulator.
package ctrl_seq_pkg;

  // Sequencer states; the encoding is exported on state_out.
  typedef enum logic [1:0] {
    OFF      = 2'd0,
    PWR_WAIT = 2'd1,
    RESET    = 2'd2,
    RUN      = 2'd3
  } ctrl_state_t;

  // Synchronised mode_select values.
  localparam logic MODE_RELAY = 1'b0;
  localparam logic MODE_GEN   = 1'b1;

  // Larger of two integers, used for sizing the shared wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_seq_emulator_pulse_stretch.sv
// Retriggerable pulse stretcher: a one-cycle trigger yields a PULSE_W-cycle
// pulse. The output is combinational from the trigger so that the caller's
// output register adds the only cycle of latency.
module pulse_stretch #(
  parameter int PULSE_W = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic trig_i,
  output logic active_o
);

  localparam int               CW     = $clog2(PULSE_W + 1);
  localparam logic [CW-1:0]    RELOAD = CW'(PULSE_W - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Remaining-width counter: clear wins, a trigger reloads, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (trig_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The trigger cycle itself is the first pulse cycle.
  assign active_o = !clr_i && (trig_i || (cnt_q != '0));

endmodule

// File: rtl/ctrl_seq_emulator.sv
// Multi-channel fast-control emulator: power/reset sequencer, orbit counter,
// relay or internal generation of QIE reset and WTE, fanned out per channel.
module ctrl_seq_emulator
  import ctrl_seq_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 12,
  parameter int ORBIT_LEN  = 3564,
  parameter int PULSE_W    = 4,
  parameter int PGOOD_DLY  = 16,
  parameter int RESET_LEN  = 8
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             pgood_in,
  input  logic             reset_switch_in,
  input  logic             mode_select_in,
  input  logic             qie_reset_in,
  input  logic             wte_in,
  input  logic             aux_in,
  input  logic [N_CH-1:0]  ch_enable_in,
  input  logic [CNT_W-1:0] wte_offset_in,
  output logic             penable_out,
  output logic             reset_out,
  output logic [N_CH-1:0]  qie_reset_out,
  output logic [N_CH-1:0]  wte_out,
  output logic [N_CH-1:0]  aux_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] orbit_cnt_out
);

  localparam int WAIT_W = $clog2(max_int(PGOOD_DLY, RESET_LEN) + 1);
  localparam logic [WAIT_W-1:0] PG_LAST   = WAIT_W'(PGOOD_DLY - 1);
  localparam logic [WAIT_W-1:0] RST_LAST  = WAIT_W'(RESET_LEN - 1);
  localparam logic [CNT_W-1:0]  ORBIT_LAST = CNT_W'(ORBIT_LEN - 1);
  localparam logic [CNT_W:0]    ORBIT_LEN_W = (CNT_W + 1)'(ORBIT_LEN);

  // Bit positions in the synchroniser vector.
  localparam int IDX_AUX   = 0;
  localparam int IDX_WTE   = 1;
  localparam int IDX_QIE   = 2;
  localparam int IDX_MODE  = 3;
  localparam int IDX_RSW   = 4;
  localparam int IDX_PGOOD = 5;

  logic [5:0] async_in;
  logic [5:0] sync1_q, sync2_q;
  logic       qie_prev_q, wte_prev_q, rsw_prev_q, mode_prev_q;

  logic pgood_s, mode_s, aux_s;
  logic qie_rise, wte_rise, rsw_rise, mode_chg;

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  orbit_q, orbit_d;

  logic run_now, run_next, trig_ok, wte_in_range;
  logic qie_trig, wte_trig, qie_act, wte_act, clr_pulse;

  logic [N_CH-1:0] qie_d, wte_d, aux_d;
  logic [N_CH-1:0] qie_q, wte_q, aux_q;
  logic            penable_q, reset_q;

  assign async_in = {pgood_in, reset_switch_in, mode_select_in,
                     qie_reset_in, wte_in, aux_in};

  // Two-flop synchroniser for every asynchronous input plus edge-detect history.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      qie_prev_q  <= 1'b0;
      wte_prev_q  <= 1'b0;
      rsw_prev_q  <= 1'b0;
      mode_prev_q <= 1'b0;
    end else begin
      sync1_q     <= async_in;
      sync2_q     <= sync1_q;
      qie_prev_q  <= sync2_q[IDX_QIE];
      wte_prev_q  <= sync2_q[IDX_WTE];
      rsw_prev_q  <= sync2_q[IDX_RSW];
      mode_prev_q <= sync2_q[IDX_MODE];
    end
  end

  assign pgood_s  = sync2_q[IDX_PGOOD];
  assign mode_s   = sync2_q[IDX_MODE];
  assign aux_s    = sync2_q[IDX_AUX];
  assign qie_rise = sync2_q[IDX_QIE] && !qie_prev_q;
  assign wte_rise = sync2_q[IDX_WTE] && !wte_prev_q;
  assign rsw_rise = sync2_q[IDX_RSW] && !rsw_prev_q;
  assign mode_chg = mode_s ^ mode_prev_q;

  // Sequencer next state; one wait counter serves both PWR_WAIT and RESET.
  // The OFF cycle that first sees pgood counts as the first stable cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!pgood_s) begin
      state_d = OFF;
      wait_d  = '0;
    end else begin
      case (state_q)
        OFF: begin
          wait_d = '0;
          if (PGOOD_DLY <= 1) begin
            state_d = RESET;
          end else begin
            state_d = PWR_WAIT;
            wait_d  = WAIT_W'(1);
          end
        end
        PWR_WAIT: begin
          if (wait_q >= PG_LAST) begin
            state_d = RESET;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        RESET: begin
          if (wait_q >= RST_LAST) begin
            state_d = RUN;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        RUN: begin
          if (rsw_rise) begin
            state_d = RESET;
            wait_d  = '0;
          end
        end
        default: begin
          state_d = OFF;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Sequencer state and wait counter registers.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= OFF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign run_now  = (state_q == RUN);
  assign run_next = (state_d == RUN);

  // Orbit counter: free-runs with wrap only while staying in RUN with a stable mode,
  // so every (re-)entry into RUN and every mode switch starts a fresh orbit at 0.
  always_comb begin
    orbit_d = '0;
    if (run_now && run_next && !mode_chg) begin
      orbit_d = (orbit_q == ORBIT_LAST) ? '0 : orbit_q + CNT_W'(1);
    end
  end

  // Orbit counter register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      orbit_q <= '0;
    end else begin
      orbit_q <= orbit_d;
    end
  end

  // Trigger selection; suppressed on the mode-switch cycle since the orbit
  // position then belongs to the previous mode.
  assign trig_ok      = run_now && !mode_chg;
  assign wte_in_range = ({1'b0, wte_offset_in} < ORBIT_LEN_W);
  assign qie_trig = trig_ok && ((mode_s == MODE_RELAY) ? qie_rise : (orbit_q == '0));
  assign wte_trig = trig_ok && ((mode_s == MODE_RELAY) ? wte_rise
                                : (wte_in_range && (orbit_q == wte_offset_in)));

  // Pulses are aborted as soon as the sequencer leaves RUN.
  assign clr_pulse = !run_next;

  pulse_stretch #(.PULSE_W(PULSE_W)) u_qie_pulse (
    .clk_i    (clk_in),
    .rst_ni   (reset_n_in),
    .clr_i    (clr_pulse),
    .trig_i   (qie_trig),
    .active_o (qie_act)
  );

  pulse_stretch #(.PULSE_W(PULSE_W)) u_wte_pulse (
    .clk_i    (clk_in),
    .rst_ni   (reset_n_in),
    .clr_i    (clr_pulse),
    .trig_i   (wte_trig),
    .active_o (wte_act)
  );

  // Per-channel gating by the channel enables.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign qie_d[gi] = qie_act && ch_enable_in[gi];
    assign wte_d[gi] = wte_act && ch_enable_in[gi];
    assign aux_d[gi] = aux_s && run_next && ch_enable_in[gi];
  end

  // Output registers, derived from the next state so they track the sequencer.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      penable_q <= 1'b0;
      reset_q   <= 1'b0;
      qie_q     <= '0;
      wte_q     <= '0;
      aux_q     <= '0;
    end else begin
      penable_q <= (state_d == RESET) || (state_d == RUN);
      reset_q   <= (state_d == RESET);
      qie_q     <= qie_d;
      wte_q     <= wte_d;
      aux_q     <= aux_d;
    end
  end

  assign penable_out   = penable_q;
  assign reset_out     = reset_q;
  assign qie_reset_out = qie_q;
  assign wte_out       = wte_q;
  assign aux_out       = aux_q;
  assign state_out     = state_q;
  assign orbit_cnt_out = orbit_q;

endmodule

// File: tb/tb_ctrl_seq_emulator.sv
// Directed bench for ctrl_seq_emulator: power-up, relay vector table,
// retrigger, reset switch, generate mode, pgood loss and async reset.
module tb_ctrl_seq_emulator;

  localparam int N_CH      = 4;
  localparam int CNT_W     = 12;
  localparam int ORBIT_LEN = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pgood = 1'b0, rsw = 1'b0, mode = 1'b0;
  logic             qie = 1'b0, wte = 1'b0, aux = 1'b0;
  logic [N_CH-1:0]  ch_en = 4'hF;
  logic [CNT_W-1:0] wte_off = 12'd5;

  logic             penable_out, reset_out;
  logic [N_CH-1:0]  qie_out, wte_out, aux_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] orbit_out;

  ctrl_seq_emulator #(
    .N_CH(N_CH), .CNT_W(CNT_W), .ORBIT_LEN(ORBIT_LEN),
    .PULSE_W(4), .PGOOD_DLY(16), .RESET_LEN(8)
  ) dut (
    .clk_in          (clk),
    .reset_n_in      (rst_n),
    .pgood_in        (pgood),
    .reset_switch_in (rsw),
    .mode_select_in  (mode),
    .qie_reset_in    (qie),
    .wte_in          (wte),
    .aux_in          (aux),
    .ch_enable_in    (ch_en),
    .wte_offset_in   (wte_off),
    .penable_out     (penable_out),
    .reset_out       (reset_out),
    .qie_reset_out   (qie_out),
    .wte_out         (wte_out),
    .aux_out         (aux_out),
    .state_out       (state_out),
    .orbit_cnt_out   (orbit_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] en;
    logic       q;
    logic       w;
    logic       a;
    logic [3:0] exp_q;
    logic [3:0] exp_w;
    logic [3:0] exp_a;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name, input int cyc);
    check({name, ".penable"}, cyc, 32'(penable_out), 32'd0);
    check({name, ".reset"},   cyc, 32'(reset_out),   32'd0);
    check({name, ".qie"},     cyc, 32'(qie_out),     32'd0);
    check({name, ".wte"},     cyc, 32'(wte_out),     32'd0);
    check({name, ".aux"},     cyc, 32'(aux_out),     32'd0);
    check({name, ".state"},   cyc, 32'(state_out),   32'd0);
    check({name, ".orbit"},   cyc, 32'(orbit_out),   32'd0);
  endtask

  // Called right after pgood (or reset release) took effect just past an edge.
  // Cycle n is the state after the n-th following clock edge.
  task automatic power_up(input string name);
    for (int n = 1; n <= 27; n++) begin
      logic [1:0] exp_st;
      tick();
      exp_st = (n <= 2) ? 2'd0 : (n <= 17) ? 2'd1 : (n <= 25) ? 2'd2 : 2'd3;
      check({name, ".penable"}, n, 32'(penable_out), 32'(n >= 18));
      check({name, ".reset"},   n, 32'(reset_out),   32'((n >= 18) && (n <= 25)));
      check({name, ".state"},   n, 32'(state_out),   32'(exp_st));
    end
    $display("[TB] %s: power-up sequence checked through cycle 27", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //               en     q     w     a     exp_q  exp_w  exp_a
    vecs[0] = '{4'b1011, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1011, 4'b0000};
    vecs[1] = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111};
    vecs[3] = '{4'b0101, 1'b1, 1'b1, 1'b0, 4'b0101, 4'b0101, 4'b0000};
    vecs[4] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111};

    // ---- 1: reset and power-up ----
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset", 0);
    rst_n = 1'b1;
    tick();
    check_all_zero("after_release", 1);
    repeat (3) tick();
    pgood = 1'b1;
    power_up("pwr_up");

    // ---- 2: relay vector table ----
    for (int v = 0; v < 6; v++) begin
      ch_en = vecs[v].en;
      qie   = vecs[v].q;
      wte   = vecs[v].w;
      aux   = vecs[v].a;
      for (int k = 1; k <= 7; k++) begin
        tick();
        check($sformatf("relay%0d.qie", v), k, 32'(qie_out),
              32'(((k >= 3) && (k <= 6)) ? vecs[v].exp_q : 4'b0000));
        check($sformatf("relay%0d.wte", v), k, 32'(wte_out),
              32'(((k >= 3) && (k <= 6)) ? vecs[v].exp_w : 4'b0000));
        check($sformatf("relay%0d.aux", v), k, 32'(aux_out),
              32'((k >= 3) ? vecs[v].exp_a : 4'b0000));
      end
      check($sformatf("relay%0d.state", v), 7, 32'(state_out), 32'd3);
      $display("[TB] relay vector %0d: en=%b qie=%b wte=%b aux=%b", v,
               vecs[v].en, vecs[v].q, vecs[v].w, vecs[v].a);
      qie = 1'b0;
      wte = 1'b0;
      aux = 1'b0;
      repeat (4) tick();
    end

    // ---- 5a: two qie edges two cycles apart -> one 6-cycle pulse ----
    ch_en = 4'hF;
    qie = 1'b1;
    tick();
    qie = 1'b0;
    tick();
    check("retrig.pre", 2, 32'(qie_out), 32'd0);
    qie = 1'b1;
    for (int k = 3; k <= 9; k++) begin
      tick();
      check("retrig.qie", k, 32'(qie_out), 32'((k <= 8) ? 4'hF : 4'h0));
    end
    qie = 1'b0;
    $display("[TB] retrigger: qie pulse width checked");
    repeat (4) tick();

    // ---- reset switch in RUN: back through RESET, orbit restarts ----
    rsw = 1'b1;
    tick();
    tick();
    check("rsw.state_pre", 2, 32'(state_out), 32'd3);
    for (int k = 3; k <= 10; k++) begin
      tick();
      check("rsw.state", k, 32'(state_out), 32'd2);
      check("rsw.reset", k, 32'(reset_out), 32'd1);
      check("rsw.penable", k, 32'(penable_out), 32'd1);
    end
    tick();
    check("rsw.state_run", 11, 32'(state_out), 32'd3);
    check("rsw.reset_low", 11, 32'(reset_out), 32'd0);
    check("rsw.orbit0", 11, 32'(orbit_out), 32'd0);
    tick();
    check("rsw.orbit1", 12, 32'(orbit_out), 32'd1);
    rsw = 1'b0;
    $display("[TB] reset switch: RESET re-entry and orbit restart checked");
    repeat (3) tick();

    // ---- 3: generate mode ----
    begin
      logic       found;
      logic [3:0] prev_q;
      mode    = 1'b1;
      wte_off = 12'd5;
      repeat (10) tick();
      found  = 1'b0;
      prev_q = qie_out;
      for (int k = 0; k < 40 && !found; k++) begin
        tick();
        if (qie_out == 4'hF && prev_q == 4'h0) found = 1'b1;
        prev_q = qie_out;
      end
      check("gen.found_qie", 0, 32'(found), 32'd1);
      check("gen.orbit_at_qie", 0, 32'(orbit_out), 32'd1);
      for (int c = 0; c < 100; c++) begin
        int ph;
        if (c > 0) tick();
        if (c == 60) wte_off = 12'd25;
        ph = c % ORBIT_LEN;
        check("gen.qie", c, 32'(qie_out), 32'((ph < 4) ? 4'hF : 4'h0));
        check("gen.wte", c, 32'(wte_out),
              32'((c < 60 && ph >= 5 && ph < 9) ? 4'hF : 4'h0));
        if (c == 59) wte_off = 12'd25;
      end
      $display("[TB] generate: qie period %0d, wte offset 5 then 25 checked", ORBIT_LEN);
    end
    mode    = 1'b0;
    wte_off = 12'd5;
    repeat (10) tick();

    // ---- 4: pgood loss mid-pulse ----
    aux = 1'b1;
    qie = 1'b1;
    repeat (4) tick();
    check("pgloss.qie_active", 4, 32'(qie_out), 32'hF);
    check("pgloss.aux_active", 4, 32'(aux_out), 32'hF);
    pgood = 1'b0;
    repeat (3) tick();
    check_all_zero("pgloss", 7);
    qie = 1'b0;
    aux = 1'b0;
    $display("[TB] pgood loss: outputs cleared within 3 cycles");
    repeat (3) tick();
    pgood = 1'b1;
    power_up("pg_return");

    // ---- 6: async reset mid-RUN ----
    aux = 1'b1;
    qie = 1'b1;
    repeat (4) tick();
    check("arst.qie_active", 4, 32'(qie_out), 32'hF);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst_immediate", 4);
    qie = 1'b0;
    aux = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("arst_held", 6);
    rst_n = 1'b1;
    $display("[TB] async reset: outputs cleared without a clock edge");
    power_up("after_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
